wishbone_bus_if: RTL and testbench
==================================

Name: wishbone_bus_if

Overview:
- Wishbone B4 classic master adapter between one openmips memory port (rom_* or ram_* side) and a shared Wishbone bus.
- Instantiated twice in the SoC top: one instance for the instruction port, one for the data port.
- Converts the core's single-cycle memory request into a multi-cycle Wishbone transaction.
- Raises a stall request to ctrl until the transaction completes.
- Holds read data stable until the pipeline actually advances.

Parameters:
- STALL_WIDTH, 6: width of the pipeline stall vector; matches the core's stall bus.
- TIMEOUT_CYCLES, 255: cycles in BUSY without ack before abort; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  STALL_WIDTH  stall vector from ctrl.
- flush_i  in  1  pipeline flush; abandons the current request.
- cpu_ce_i  in  1  core request valid (rom_ce_o or ram_ce_o).
- cpu_addr_i  in  32  byte address.
- cpu_data_i  in  32  write data.
- cpu_we_i  in  1  1 = write.
- cpu_sel_i  in  4  byte lane select; tie to 4'b1111 for the instruction port.
- cpu_data_o  out  32  read data to the core.
- stallreq  out  1  stall request to ctrl.
- wb_data_i  in  32  Wishbone DAT_I.
- wb_ack_i  in  1  Wishbone ACK_I.
- wb_addr_o  out  32  ADR_O.
- wb_data_o  out  32  DAT_O.
- wb_we_o  out  1  WE_O.
- wb_sel_o  out  4  SEL_O.
- wb_stb_o  out  1  STB_O.
- wb_cyc_o  out  1  CYC_O.

Behaviour:

Reset (rst=1 at a clock edge):
- State goes to IDLE.
- All wb_* outputs go to 0.
- Read buffer rd_buf is cleared to 0.
- cpu_data_o=0 and stallreq=0 while in reset.

States:

IDLE:
- If cpu_ce_i=1 and flush_i=0:
  - Register cpu_addr_i, cpu_data_i, cpu_we_i and cpu_sel_i onto wb_addr_o, wb_data_o, wb_we_o and wb_sel_o.
  - Set wb_stb_o=1 and wb_cyc_o=1.
  - Go to BUSY.
- Combinational outputs in IDLE: stallreq=cpu_ce_i&~flush_i; cpu_data_o=0.

BUSY:
- If wb_ack_i=1:
  - Drop wb_stb_o, wb_cyc_o and wb_we_o to 0; clear wb_addr_o, wb_data_o and wb_sel_o to 0.
  - If the transaction was a read, latch wb_data_i into rd_buf.
  - If stall_i!=0, go to WAIT_FOR_STALL; otherwise go to IDLE.
- If no ack, hold all wb_* outputs unchanged.
- Combinational outputs in BUSY:
  - stallreq=~wb_ack_i.
  - cpu_data_o: on the ack cycle of a read, wb_data_i passes through combinationally; otherwise 0.

WAIT_FOR_STALL:
- Combinational outputs: stallreq=0; cpu_data_o=rd_buf.
- When stall_i==0, go to IDLE.

Flush:
- flush_i=1 in BUSY: drop stb, cyc and we immediately and go to IDLE. A late ack is ignored.
- flush_i=1 in WAIT_FOR_STALL: go to IDLE.
- stallreq=0 whenever flush_i=1.

Protocol and timing rules:
- Latency: minimum 2 cycles from request to data (one cycle registering into BUSY, ack at the earliest on the next cycle).
- One outstanding transaction; no pipelined or burst Wishbone cycles.
- wb_cyc_o always equals wb_stb_o.
- wb_ack_i is ignored outside BUSY.
- Back-to-back: a new cpu_ce_i seen in IDLE starts on the cycle immediately after returning to IDLE.

Optional Feature:
- Macro WB_TIMEOUT_EN.
- When defined:
  - An 8-bit or wider counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: drop stb and cyc, set rd_buf=32'hDEADBEEF, deassert stallreq that cycle, and move to the state ack would have selected.
  - Sticky output port timeout_o (1 bit) is set; it clears only on rst.
- When undefined: no counter, no timeout_o port; BUSY waits on ack forever.

Test Plan:
1. Read, no stall: cpu_ce_i=1, we=0, addr=32'h0000_0010; slave acks 3 cycles after stb with 32'h1234_5678 -> stallreq=1 for 3 cycles; cpu_data_o=32'h1234_5678 on the ack cycle; state returns to IDLE; stb and cyc are 0 the next cycle.
2. Write with byte lanes: we=1, sel=4'b0011, data=32'hAABB_CCDD, addr=32'h40 -> wb_* outputs carry exactly these values while stb=1; after ack, stb, cyc and we are 0 and cpu_data_o=0.
3. Held pipeline: read returns 32'hCAFE_0001 while stall_i=6'b011111 is held 4 cycles by another source -> WAIT_FOR_STALL; cpu_data_o=32'hCAFE_0001 and stallreq=0 every held cycle; IDLE once stall_i=0.
4. Flush mid-transaction: flush_i pulsed in BUSY before ack -> stb and cyc drop the next cycle; a later ack produces no data and no state change; stallreq=0.
5. Reset mid-operation: rst=1 for 1 cycle in BUSY -> all wb_* outputs=0, cpu_data_o=0, state IDLE; a following request starts normally.
6. WB_TIMEOUT_EN with TIMEOUT_CYCLES=8: no ack -> abort after 8 BUSY cycles; cpu_data_o=32'hDEADBEEF; timeout_o=1 until rst.

Source files
------------

// File: rtl/wishbone_bus_if.sv
// Wishbone B4 classic master adapter for one openmips memory port (instruction or data side).
// Define WB_TIMEOUT_EN to add a BUSY watchdog that aborts stuck cycles and raises a sticky timeout_o.
module wishbone_bus_if #(
    parameter int STALL_WIDTH = 6
`ifdef WB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   flush_i,
    input  logic                   cpu_ce_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_data_i,
    input  logic                   cpu_we_i,
    input  logic [3:0]             cpu_sel_i,
    output logic [31:0]            cpu_data_o,
    output logic                   stallreq,
    input  logic [31:0]            wb_data_i,
    input  logic                   wb_ack_i,
    output logic [31:0]            wb_addr_o,
    output logic [31:0]            wb_data_o,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o,
    output logic                   wb_stb_o,
    output logic                   wb_cyc_o
`ifdef WB_TIMEOUT_EN
    ,
    output logic                   timeout_o
`endif
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    state_t      state;
    state_t      state_next;
    logic [31:0] rd_buf;
    logic        start;
    logic        ack_hit;
    logic        abort_hit;
    logic        done;
    logic        stall_any;

    assign start     = (state == IDLE) && cpu_ce_i && !flush_i;
    // A flush in BUSY wins over a coincident ack: the request is abandoned.
    assign ack_hit   = (state == BUSY) && wb_ack_i && !flush_i;
    assign done      = ack_hit || abort_hit;
    assign stall_any = |stall_i;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    // The abort fires in the BUSY cycle whose missing ack would bring the count to TIMEOUT_CYCLES.
    assign abort_hit = (state == BUSY) && !wb_ack_i && !flush_i &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (start) begin
                to_cnt <= '0;
            end else if ((state == BUSY) && !wb_ack_i) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (abort_hit) begin
                timeout_o <= 1'b1;
            end
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = stall_any ? WAIT_FOR_STALL : IDLE;
                end
            end
            WAIT_FOR_STALL: begin
                if (flush_i || !stall_any) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = 32'd0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    stallreq = cpu_ce_i && !flush_i;
                end
                BUSY: begin
                    stallreq = !wb_ack_i && !flush_i && !abort_hit;
                    // Read data bypasses rd_buf on the ack cycle so an unstalled pipeline takes it at once.
                    if (ack_hit && !wb_we_o) begin
                        cpu_data_o = wb_data_i;
                    end else if (abort_hit) begin
                        cpu_data_o = ABORT_DATA;
                    end
                end
                WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: begin
                    stallreq   = 1'b0;
                    cpu_data_o = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr_o <= 32'd0;
            wb_data_o <= 32'd0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'd0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= 32'd0;
        end else begin
            if (start) begin
                wb_addr_o <= cpu_addr_i;
                wb_data_o <= cpu_data_i;
                wb_we_o   <= cpu_we_i;
                wb_sel_o  <= cpu_sel_i;
                wb_stb_o  <= 1'b1;
                wb_cyc_o  <= 1'b1;
            end else if ((state == BUSY) && (flush_i || done)) begin
                wb_addr_o <= 32'd0;
                wb_data_o <= 32'd0;
                wb_we_o   <= 1'b0;
                wb_sel_o  <= 4'd0;
                wb_stb_o  <= 1'b0;
                wb_cyc_o  <= 1'b0;
            end
            if (ack_hit && !wb_we_o) begin
                rd_buf <= wb_data_i;
            end else if (abort_hit) begin
                rd_buf <= ABORT_DATA;
            end
        end
    end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed bench for wishbone_bus_if: expected read data travels through a scoreboard queue.
// Build with WB_TIMEOUT_EN defined to also exercise the BUSY watchdog (TIMEOUT_CYCLES=8).
module tb_wishbone_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
`ifdef WB_TIMEOUT_EN
    logic        timeout_o;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'd0;

    always #5 clk = ~clk;

`ifdef WB_TIMEOUT_EN
    wishbone_bus_if #(.STALL_WIDTH(6), .TIMEOUT_CYCLES(8)) dut (
`else
    wishbone_bus_if #(.STALL_WIDTH(6)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .cpu_ce_i  (cpu_ce_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_sel_i (cpu_sel_i),
        .cpu_data_o(cpu_data_o),
        .stallreq  (stallreq),
        .wb_data_i (wb_data_i),
        .wb_ack_i  (wb_ack_i),
        .wb_addr_o (wb_addr_o),
        .wb_data_o (wb_data_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o)
`ifdef WB_TIMEOUT_EN
        ,
        .timeout_o (timeout_o)
`endif
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk_bus_idle(input string tag);
        chk1({tag, "_stb"}, wb_stb_o, 1'b0);
        chk1({tag, "_cyc"}, wb_cyc_o, 1'b0);
        chk1({tag, "_we"}, wb_we_o, 1'b0);
        chk32({tag, "_addr"}, wb_addr_o, 32'd0);
        chk32({tag, "_dat"}, wb_data_o, 32'd0);
        chk32({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
    endtask

    // Starts in the current cycle, acks after busy_wait non-ack BUSY cycles, returns just past the ack edge.
    task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel,
                          input int busy_wait, input logic [5:0] stall_at_ack);
        logic [31:0] exp_rd;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = we ? data : 32'd0;
        cpu_sel_i  = sel;
        if (!we) exp_q.push_back(data);
        at_neg();
        chk1({tag, "_req_stallreq"}, stallreq, 1'b1);
        chk32({tag, "_req_rdata"}, cpu_data_o, 32'd0);
        tick();
        cpu_ce_i   = 1'b0;
        cpu_data_i = 32'd0;
        for (int i = 0; i < busy_wait; i++) begin
            at_neg();
            chk1({tag, "_busy_stb"}, wb_stb_o, 1'b1);
            chk1({tag, "_busy_cyc"}, wb_cyc_o, 1'b1);
            chk1({tag, "_busy_we"}, wb_we_o, we);
            chk32({tag, "_busy_addr"}, wb_addr_o, addr);
            chk32({tag, "_busy_dat"}, wb_data_o, we ? data : 32'd0);
            chk32({tag, "_busy_sel"}, {28'd0, wb_sel_o}, {28'd0, sel});
            chk1({tag, "_busy_stallreq"}, stallreq, 1'b1);
            tick();
        end
        wb_ack_i  = 1'b1;
        wb_data_i = we ? 32'h5555_AAAA : data;
        stall_i   = stall_at_ack;
        at_neg();
        chk1({tag, "_ack_stallreq"}, stallreq, 1'b0);
        chk1({tag, "_ack_stb"}, wb_stb_o, 1'b1);
        if (!we) begin
            if (exp_q.size() == 0) begin
                chk32({tag, "_ack_sb_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                exp_rd  = exp_q.pop_front();
                last_rd = exp_rd;
                chk32({tag, "_ack_rdata"}, cpu_data_o, exp_rd);
            end
        end else begin
            chk32({tag, "_ack_rdata"}, cpu_data_o, 32'd0);
        end
        tick();
        wb_ack_i  = 1'b0;
        wb_data_i = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        stall_i    = 6'd0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_addr_i = 32'h0000_0004;
        cpu_data_i = 32'd0;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        wb_data_i  = 32'h1111_2222;
        wb_ack_i   = 1'b1;

        // Reset: a request and a stray ack during reset must have no effect.
        tick();
        tick();
        at_neg();
        chk1("rst_stallreq", stallreq, 1'b0);
        chk32("rst_rdata", cpu_data_o, 32'd0);
        chk_bus_idle("rst");
        tick();
        rst        = 1'b0;
        cpu_ce_i   = 1'b0;
        wb_ack_i   = 1'b0;
        wb_data_i  = 32'd0;
        at_neg();
        chk_bus_idle("post_rst");

        // Read, no stall: two quiet BUSY cycles, ack on the third.
        tick();
        do_txn("rd1", 1'b0, 32'h0000_0010, 32'h1234_5678, 4'hF, 2, 6'd0);
        at_neg();
        chk_bus_idle("rd1_after");
        chk1("rd1_after_stallreq", stallreq, 1'b0);
        chk32("rd1_after_rdata", cpu_data_o, 32'd0);

        // Write with byte lanes.
        tick();
        do_txn("wr", 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0011, 1, 6'd0);
        at_neg();
        chk_bus_idle("wr_after");
        chk32("wr_after_rdata", cpu_data_o, 32'd0);

        // Back-to-back minimum-latency reads: the second starts in the IDLE cycle right after the first.
        tick();
        do_txn("b2b_a", 1'b0, 32'h0000_0100, 32'h0BAD_F00D, 4'hF, 0, 6'd0);
        do_txn("b2b_b", 1'b0, 32'h0000_0104, 32'h7654_3210, 4'hF, 0, 6'd0);
        at_neg();
        chk_bus_idle("b2b_after");

        // Held pipeline: read data stays on cpu_data_o while stall_i is held by another source.
        tick();
        do_txn("hold", 1'b0, 32'h0000_0020, 32'hCAFE_0001, 4'hF, 1, 6'b011111);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk32("hold_rdata", cpu_data_o, last_rd);
            chk1("hold_stallreq", stallreq, 1'b0);
            chk1("hold_stb", wb_stb_o, 1'b0);
            tick();
        end
        stall_i = 6'd0;
        at_neg();
        chk32("hold_release_rdata", cpu_data_o, last_rd);
        tick();
        at_neg();
        chk32("hold_idle_rdata", cpu_data_o, 32'd0);
        chk1("hold_idle_stallreq", stallreq, 1'b0);

        // Flush in BUSY before ack; the late ack must be ignored.
        tick();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0030;
        tick();
        cpu_ce_i = 1'b0;
        flush_i  = 1'b1;
        at_neg();
        chk1("flush_busy_stallreq", stallreq, 1'b0);
        chk1("flush_busy_stb", wb_stb_o, 1'b1);
        tick();
        flush_i = 1'b0;
        at_neg();
        chk_bus_idle("flush_drop");
        tick();
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hDEAD_0BAD;
        at_neg();
        chk32("flush_late_ack_rdata", cpu_data_o, 32'd0);
        chk1("flush_late_ack_stallreq", stallreq, 1'b0);
        tick();
        wb_ack_i  = 1'b0;
        wb_data_i = 32'd0;
        at_neg();
        chk_bus_idle("flush_late_ack_after");

        // Flush in IDLE suppresses a new request.
        cpu_ce_i = 1'b1;
        flush_i  = 1'b1;
        at_neg();
        chk1("flush_idle_stallreq", stallreq, 1'b0);
        tick();
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        at_neg();
        chk1("flush_idle_stb", wb_stb_o, 1'b0);

        // Flush in WAIT_FOR_STALL returns to IDLE although stall is still held.
        tick();
        do_txn("wflush", 1'b0, 32'h0000_0024, 32'h0F0F_1234, 4'hF, 0, 6'b000100);
        at_neg();
        chk32("wflush_wait_rdata", cpu_data_o, last_rd);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        at_neg();
        chk32("wflush_idle_rdata", cpu_data_o, 32'd0);
        chk1("wflush_idle_stallreq", stallreq, 1'b0);
        stall_i = 6'd0;

        // Reset in BUSY, then a normal request.
        tick();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h0000_0050;
        cpu_data_i = 32'h1357_9BDF;
        cpu_sel_i  = 4'b1100;
        tick();
        cpu_ce_i = 1'b0;
        rst      = 1'b1;
        at_neg();
        chk1("rstbusy_stallreq", stallreq, 1'b0);
        chk32("rstbusy_rdata", cpu_data_o, 32'd0);
        chk1("rstbusy_stb_before_edge", wb_stb_o, 1'b1);
        tick();
        rst = 1'b0;
        at_neg();
        chk_bus_idle("rstbusy_after");
        chk1("rstbusy_after_stallreq", stallreq, 1'b0);
        tick();
        do_txn("post_rst_rd", 1'b0, 32'h0000_0060, 32'h600D_D00D, 4'hF, 1, 6'd0);
        at_neg();
        chk_bus_idle("post_rst_rd_after");

`ifdef WB_TIMEOUT_EN
        // Watchdog: no ack ever; abort in the eighth BUSY cycle.
        tick();
        chk1("to_initial", timeout_o, 1'b0);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0070;
        cpu_sel_i  = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            at_neg();
            chk1("to_wait_stallreq", stallreq, 1'b1);
            tick();
        end
        at_neg();
        chk1("to_abort_stallreq", stallreq, 1'b0);
        chk32("to_abort_rdata", cpu_data_o, 32'hDEAD_BEEF);
        tick();
        at_neg();
        chk1("to_after_stb", wb_stb_o, 1'b0);
        chk1("to_after_cyc", wb_cyc_o, 1'b0);
        chk1("to_sticky", timeout_o, 1'b1);
        tick();
        tick();
        at_neg();
        chk1("to_sticky_later", timeout_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        chk1("to_cleared_by_rst", timeout_o, 1'b0);
`endif

        chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
